present_inv_key_sched: RTL and testbench

- Decryption-side key schedule for PRESENT-80. It is the inverse of the forward per-round key update.
- Accepts an 80-bit master key and expands it forward to the final key state K32, then steps backward. It issues round keys K32, K31, … K1 over a valid/ready stream into the decryption datapath.
- One round key is emitted per accepted transfer.

---
 rtl/present_inv_key_sched.sv | 165 ++++++++++++++++
 tb/tb_present_inv_key_sched.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/present_inv_key_sched.sv
// PRESENT-80 decryption key schedule: expands the master key forward to K32, then streams K32..K1.
// Optional last-key cache enabled by defining PRESENT_INV_KEY_CACHE_EN.
module present_inv_key_sched #(
  parameter int KEY_W  = 80,
  parameter int RK_W   = 64,
  parameter int ROUNDS = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [KEY_W-1:0]  key_in,
  output logic              busy,
  output logic              rk_valid,
  input  logic              rk_ready,
  output logic [RK_W-1:0]   rk_out,
  output logic [5:0]        rk_idx,
  output logic              done
);

  localparam logic [4:0] LAST_RND  = 5'(ROUNDS);
  localparam logic [5:0] FIRST_IDX = 6'(ROUNDS + 1);

  typedef enum logic [1:0] {IDLE, FWD, REV, DONE} state_t;

  state_t            state_reg;
  logic [KEY_W-1:0]  kreg;
  logic [4:0]        cnt;
  logic [KEY_W-1:0]  fwd_next;
  logic [KEY_W-1:0]  inv_next;
  logic [4:0]        inv_rnd;

`ifdef PRESENT_INV_KEY_CACHE_EN
  logic [KEY_W-1:0]  key_hold;
  logic [KEY_W-1:0]  cache_tag;
  logic [KEY_W-1:0]  cache_k32;
  logic              cache_vld;
  logic              cache_hit;
`endif

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
      4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
      4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
      4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
    endcase
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    case (x)
      4'h0: sbox_inv = 4'h5;  4'h1: sbox_inv = 4'hE;  4'h2: sbox_inv = 4'hF;  4'h3: sbox_inv = 4'h8;
      4'h4: sbox_inv = 4'hC;  4'h5: sbox_inv = 4'h1;  4'h6: sbox_inv = 4'h2;  4'h7: sbox_inv = 4'hD;
      4'h8: sbox_inv = 4'hB;  4'h9: sbox_inv = 4'h4;  4'hA: sbox_inv = 4'h6;  4'hB: sbox_inv = 4'h3;
      4'hC: sbox_inv = 4'h0;  4'hD: sbox_inv = 4'h7;  4'hE: sbox_inv = 4'h9;  default: sbox_inv = 4'hA;
    endcase
  endfunction

  function automatic logic [KEY_W-1:0] key_fwd(input logic [KEY_W-1:0] k, input logic [4:0] i);
    logic [KEY_W-1:0] r;
    r          = {k[18:0], k[79:19]};
    r[79:76]   = sbox(r[79:76]);
    r[19:15]   = r[19:15] ^ i;
    return r;
  endfunction

  // Undo key_fwd step by step in reverse order: counter, S-box, then rotation.
  function automatic logic [KEY_W-1:0] key_inv(input logic [KEY_W-1:0] k, input logic [4:0] i);
    logic [KEY_W-1:0] r;
    r          = k;
    r[19:15]   = r[19:15] ^ i;
    r[79:76]   = sbox_inv(r[79:76]);
    return {r[60:0], r[79:61]};
  endfunction

  assign inv_rnd  = 5'(rk_idx - 6'd1);
  assign fwd_next = key_fwd(kreg, cnt);
  assign inv_next = key_inv(kreg, inv_rnd);
  assign rk_out   = kreg[KEY_W-1 -: RK_W];

`ifdef PRESENT_INV_KEY_CACHE_EN
  assign cache_hit = cache_vld && (key_in == cache_tag);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      kreg      <= '0;
      cnt       <= '0;
      rk_idx    <= '0;
      rk_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef PRESENT_INV_KEY_CACHE_EN
      key_hold  <= '0;
      cache_tag <= '0;
      cache_k32 <= '0;
      cache_vld <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
`ifdef PRESENT_INV_KEY_CACHE_EN
            if (cache_hit) begin
              kreg      <= cache_k32;
              rk_idx    <= FIRST_IDX;
              rk_valid  <= 1'b1;
              state_reg <= REV;
            end else begin
              kreg      <= key_in;
              key_hold  <= key_in;
              cnt       <= 5'd1;
              state_reg <= FWD;
            end
`else
            kreg      <= key_in;
            cnt       <= 5'd1;
            state_reg <= FWD;
`endif
          end
        end

        FWD: begin
          kreg <= fwd_next;
          if (cnt == LAST_RND) begin
            // cnt is held here rather than wrapping to 0
            rk_idx    <= FIRST_IDX;
            rk_valid  <= 1'b1;
            state_reg <= REV;
`ifdef PRESENT_INV_KEY_CACHE_EN
            cache_tag <= key_hold;
            cache_k32 <= fwd_next;
            cache_vld <= 1'b1;
`endif
          end else begin
            cnt <= cnt + 5'd1;
          end
        end

        REV: begin
          if (rk_ready) begin
            if (rk_idx == 6'd1) begin
              rk_valid  <= 1'b0;
              done      <= 1'b1;
              state_reg <= DONE;
            end else begin
              kreg   <= inv_next;
              rk_idx <= rk_idx - 6'd1;
            end
          end
        end

        DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_present_inv_key_sched.sv
// Directed bench for present_inv_key_sched: hand vectors plus a forward PRESENT-80 key model.
module tb_present_inv_key_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [79:0] key_in = '0;
  logic        rk_ready = 1'b0;
  logic        busy, rk_valid, done;
  logic [63:0] rk_out;
  logic [5:0]  rk_idx;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] exp_rk [1:32];
  logic [63:0] cap    [1:32];
  logic [63:0] cap0   [1:32];
  logic [63:0] capf   [1:32];

  typedef struct {
    logic [79:0] key;
    int          idx;
    logic [63:0] rk;
  } vec_t;
  vec_t tab [7];

  present_inv_key_sched dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in),
    .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .rk_out(rk_out), .rk_idx(rk_idx), .done(done)
  );

  always #5 clk = ~clk;

`ifdef PRESENT_INV_KEY_CACHE_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = 32;
`endif

  task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Forward PRESENT-80 schedule written with shifts and a nibble table.
  task automatic model_keys(input logic [79:0] key);
    logic [79:0] k;
    logic [63:0] sb;
    logic [3:0]  n;
    sb = 64'hC56B90AD3EF84712;
    k  = key;
    exp_rk[1] = k[79:16];
    for (int i = 1; i <= 31; i++) begin
      k = (k << 61) | (k >> 19);
      n = k[79:76];
      k[79:76] = sb[63 - 4*n -: 4];
      k = k ^ (80'(i) << 15);
      exp_rk[i+1] = k[79:16];
    end
  endtask

  task automatic run_sched(input logic [79:0] key, input int exp_lat, input bit stall,
                           input bit inject, input bit hold_start);
    int lat, nx, cyc, idle, exp_idx;
    bit stalled;
    logic [63:0] prev_out;
    logic [5:0]  prev_idx;
    model_keys(key);
    for (int i = 1; i <= 32; i++) cap[i] = '0;
    key_in   = key;
    start    = 1'b1;
    rk_ready = 1'b0;
    @(posedge clk); #1;
    start = hold_start;
    if (inject) key_in = ~key;
    lat = 1;
    while (!rk_valid && lat < 64) begin
      start = (inject && lat == 10) ? 1'b1 : hold_start;
      if (lat == 5) check("busy_fwd", 80'(busy), 80'd1);
      @(posedge clk); #1;
      lat++;
    end
    start = hold_start;
    check("latency", 80'(lat), 80'(exp_lat));
    nx = 0; cyc = 0; idle = 0; exp_idx = 32; stalled = 1'b0;
    prev_out = '0; prev_idx = '0;
    while (nx < 32 && cyc < 600) begin
      if (stall && idle > 0) begin
        rk_ready = 1'b0;
        idle--;
      end else begin
        rk_ready = 1'b1;
      end
      start = (inject && nx == 5) ? 1'b1 : hold_start;
      check("valid_held", 80'(rk_valid), 80'd1);
      check("busy_rev", 80'(busy), 80'd1);
      if (stalled) begin
        check("stall_rk_out", 80'(rk_out), 80'(prev_out));
        check("stall_rk_idx", 80'(rk_idx), 80'(prev_idx));
      end
      if (rk_valid && rk_ready) begin
        check("rk_idx_order", 80'(rk_idx), 80'(exp_idx));
        if (rk_idx >= 6'd1 && rk_idx <= 6'd32) cap[rk_idx] = rk_out;
        $display("xfer key=%h idx=%0d rk=%h", key, rk_idx, rk_out);
        nx++;
        exp_idx--;
        stalled = 1'b0;
        if (stall) idle = $urandom_range(0, 5);
      end else begin
        stalled  = rk_valid;
        prev_out = rk_out;
        prev_idx = rk_idx;
      end
      @(posedge clk); #1;
      cyc++;
    end
    rk_ready = 1'b0;
    check("xfer_count", 80'(nx), 80'd32);
    check("done_pulse", 80'(done), 80'd1);
    check("valid_after_k1", 80'(rk_valid), 80'd0);
    check("busy_in_done", 80'(busy), 80'd1);
    @(posedge clk); #1;
    check("done_clear", 80'(done), 80'd0);
    check("busy_clear", 80'(busy), 80'd0);
    if (hold_start) begin
      @(posedge clk); #1;
      check("held_restart", 80'(busy), 80'd1);
    end
    start = 1'b0;
    for (int r = 1; r <= 32; r++) check("rk_vs_model", 80'(cap[r]), 80'(exp_rk[r]));
  endtask

  initial begin
    int w;
    tab[0] = '{80'h0, 1, 64'h0000000000000000};
    tab[1] = '{80'h0, 2, 64'hC000000000000000};
    tab[2] = '{80'h0, 3, 64'h5000180000000001};
    tab[3] = '{80'h0, 4, 64'h60000A0003000001};
    tab[4] = '{80'h0, 5, 64'hB0000C0001400062};
    tab[5] = '{80'hFFFFFFFFFFFFFFFFFFFF, 1, 64'hFFFFFFFFFFFFFFFF};
    tab[6] = '{80'hFFFFFFFFFFFFFFFFFFFF, 2, 64'h2FFFFFFFFFFFFFFF};

    #3;
    check("rst_busy", 80'(busy), 80'd0);
    check("rst_valid", 80'(rk_valid), 80'd0);
    check("rst_rk_out", 80'(rk_out), 80'd0);
    check("rst_rk_idx", 80'(rk_idx), 80'd0);
    check("rst_done", 80'(done), 80'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    run_sched(80'h0, 32, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 32; i++) cap0[i] = cap[i];
    run_sched(80'hFFFFFFFFFFFFFFFFFFFF, 32, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 32; i++) capf[i] = cap[i];
    run_sched(80'hFFFFFFFFFFFFFFFFFFFF, HIT_LAT, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 32; i++) check("stall_vs_nostall", 80'(cap[i]), 80'(capf[i]));
    run_sched(80'hFFFFFFFFFFFFFFFFFFFF, HIT_LAT, 1'b0, 1'b1, 1'b0);
    run_sched(80'h0, 32, 1'b0, 1'b1, 1'b0);
    run_sched(80'h0, HIT_LAT, 1'b0, 1'b0, 1'b1);

    // The held-start restart is now running; abort it with reset at rk_idx 17.
    rk_ready = 1'b1;
    w = 0;
    while (!(rk_valid && rk_idx == 6'd17) && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    check("reach_idx17", 80'(rk_idx), 80'd17);
    #2;
    rst = 1'b0;
    rk_ready = 1'b0;
    #1;
    check("arst_busy", 80'(busy), 80'd0);
    check("arst_valid", 80'(rk_valid), 80'd0);
    check("arst_rk_out", 80'(rk_out), 80'd0);
    check("arst_rk_idx", 80'(rk_idx), 80'd0);
    check("arst_done", 80'(done), 80'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("idle_after_rst", 80'(rk_valid | busy), 80'd0);
    end
    run_sched(80'h0123456789ABCDEF0123, 32, 1'b0, 1'b0, 1'b0);
    run_sched(80'h0123456789ABCDEF0123, HIT_LAT, 1'b1, 1'b0, 1'b0);
    run_sched(80'h3C3C3C3C3C3C3C3C3C3C, 32, 1'b0, 1'b0, 1'b0);

    for (int t = 0; t < 7; t++) begin
      logic [63:0] got;
      got = (tab[t].key == 80'h0) ? cap0[tab[t].idx] : capf[tab[t].idx];
      $display("vector key=%h idx=%0d rk=%h", tab[t].key, tab[t].idx, got);
      check("hand_vector", 80'(got), 80'(tab[t].rk));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
